// File: rtl/numa_pkg.sv
// rtl/numa_pkg.sv - shared NUMA frame layout and framer state encoding
package numa_pkg;

    localparam int FRAME_BYTES = 12;
    localparam int FRAME_BITS  = 96;

    // Byte offsets of each word inside the frame, MSB first within a word
    localparam int LAT_OFS = 0;
    localparam int LON_OFS = 4;
    localparam int TS_OFS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/numa_byte_shifter.sv
// rtl/numa_byte_shifter.sv - holds the active frame and selects the current byte
module numa_byte_shifter
    import numa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  advance,
    output logic [7:0]            data,
    output logic                  last_byte
);

    logic [FRAME_BITS-1:0] active;
    logic [FRAME_BITS-1:0] aligned;
    logic [3:0]            byte_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active   <= '0;
            byte_idx <= '0;
        end else if (load) begin
            active   <= frame;
            byte_idx <= '0;
        end else if (advance && !last_byte) begin
            byte_idx <= byte_idx + 4'd1;
        end
    end

    // Left-align the selected byte so the output is always the top 8 bits
    assign aligned   = active << {byte_idx, 3'b000};
    assign data      = aligned[FRAME_BITS-1 -: 8];
    assign last_byte = (byte_idx == 4'(FRAME_BYTES - 1));

endmodule

// File: rtl/numa_framer.sv
// rtl/numa_framer.sv - serializes lat/lon/timestamp triples into 12-byte frames
module numa_framer
    import numa_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      latitude,
    input  logic [31:0]      longitude,
    input  logic [31:0]      timestamp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             busy
);

    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                state, state_next;
    logic [FRAME_BITS-1:0] pend;
    logic                  pend_full;
    logic                  load, transfer, accept, frame_end, last_byte;
    logic [3:0]            gap_cnt;
    logic [7:0]            shift_byte;

    assign in_ready = !pend_full;
    assign load     = in_valid && in_ready;
    assign busy     = (state != IDLE) || pend_full;
    assign data_out = data_valid ? shift_byte : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        transfer   = 1'b0;
        data_valid = 1'b0;
        accept     = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_full) begin
                    transfer   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                data_valid = 1'b1;
                accept     = data_ready;
                if (data_ready && last_byte) begin
                    frame_end  = 1'b1;
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load and transfer are mutually exclusive: one needs the slot empty, the other full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend        <= '0;
            pend_full   <= 1'b0;
            gap_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) frame_count <= frame_count + CNT_W'(1);
            if (load) begin
                pend      <= {latitude, longitude, timestamp};
                pend_full <= 1'b1;
            end else if (transfer) begin
                pend_full <= 1'b0;
            end
            if (state == GAP) gap_cnt <= gap_cnt + 4'd1;
            else              gap_cnt <= '0;
        end
    end

    numa_byte_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (transfer),
        .frame     (pend),
        .advance   (accept),
        .data      (shift_byte),
        .last_byte (last_byte)
    );

endmodule

// File: doc/numa_framer.md
# numa_framer

Transmit-side counterpart of the NUMA position parser. Accepts a latitude/longitude/timestamp triple through a valid/ready handshake and serializes it as a 12-byte big-endian frame (latitude[31:24] first, timestamp[7:0] last), the exact byte order the parser consumes. It sits between the timing/position core and the byte link (UART or SPI transmitter). A one-deep pending slot lets the next triple be loaded while a frame is on the wire.

## Interface
- GAP_CYCLES, 2: idle cycles forced after each frame. The range is 0–15. An extra IDLE cycle always follows the gap.
- CNT_W, 16: width of frame_count.

- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset; one clock domain
- latitude  in  32  position word, sampled on load
- longitude  in  32  position word, sampled on load
- timestamp  in  32  time word, sampled on load
- in_valid  in  1  load request
- in_ready  out  1  pending slot empty; equals !pend_full
- data_out  out  8  current frame byte; 0 when data_valid is low
- data_valid  out  1  byte available
- data_ready  in  1  downstream accepts byte
- frame_done  out  1  one-cycle pulse after the last byte is accepted
- frame_count  out  CNT_W  frames completed; wraps modulo 2^CNT_W
- busy  out  1  state != IDLE or pend_full

## Operation
- Load: when in_valid && in_ready at an edge, {latitude, longitude, timestamp} → pend[95:0] and pend_full=1. When in_ready=0, in_valid is ignored; the inputs need not be held.
- States: IDLE, SEND, GAP.
- IDLE: if pend_full, then pend → active[95:0], pend_full=0, byte_idx=0, and → SEND. Otherwise stay in IDLE.
- SEND:
  - data_valid=1.
  - data_out=active[95-8*byte_idx -: 8].
  - On data_valid && data_ready: if byte_idx<11, byte_idx+1.
  - On data_valid && data_ready with byte_idx==11: frame_done=1 next cycle, frame_count+1, and → GAP (→ IDLE if GAP_CYCLES==0).
- GAP: gap_cnt counts GAP_CYCLES cycles with data_valid=0, then → IDLE.
- Loading a new triple never corrupts an in-flight frame. Only pend is written during SEND or GAP; active changes only in IDLE.
- A load and the pend→active transfer cannot occur on the same edge: load requires pend_full=0, transfer requires pend_full=1.
- Byte order is fixed by the parser: bytes 0–3 latitude, 4–7 longitude, 8–11 timestamp, MSB first within each word.

## Timing
- Reset values while rst=0: state=IDLE, data_valid=0, data_out=0, frame_done=0, frame_count=0, pend_full=0 (so in_ready=1), busy=0, byte_idx=0, gap_cnt=0.
- Reset mid-frame: data_valid drops immediately (asynchronously). The partial frame and pending slot are discarded; nothing is resumed after reset.
- Latency from accept at edge N while IDLE:
  - pend_full=1 after N.
  - Transfer at N+1; data_valid=1 and byte 0 on data_out after N+1.
  - in_ready=1 again after N+1.
- Throughput: one byte per cycle while data_ready=1. A frame with continuous ready occupies 12 SEND cycles, then GAP_CYCLES cycles, then 1 IDLE cycle.
- data_out and data_valid hold stable while data_valid && !data_ready; backpressure of any length is legal.
- The pending slot stays full across a frame. The next frame's byte 0 appears GAP_CYCLES+1 cycles after the edge that accepted byte 11, then transfers on that IDLE edge.
- frame_done coincides with the first GAP (or IDLE) cycle. frame_count updates on the same edge.
- frame_count wraps 2^CNT_W−1 → 0 with no flag.

## Structure
- numa_pkg holds:
  - FRAME_BYTES=12 and FRAME_BITS=96.
  - Byte offsets: LAT_OFS=0, LON_OFS=4, TS_OFS=8.
  - The state encoding IDLE/SEND/GAP.
- The parser side imports the same package so both ends share one definition of the frame layout.
- One natural sub-module, numa_byte_shifter: holds active[95:0] and byte_idx, and produces data_out and a last_byte flag. The framer FSM owns the handshake, the pending slot, the gap counter and frame_count.

## Test plan
- Single frame, data_ready=1, load lat=0x11223344, lon=0x55667788, ts=0x99AABBCC:
  - bytes 11,22,…,CC in order, one per cycle, starting 2 cycles after accept;
  - frame_done pulses once;
  - frame_count=1.
- Backpressure: data_ready toggles 1,0,0,1 repeatedly → every byte stays stable while stalled, no byte is lost or duplicated, and the frame matches the reference model.
- Back-to-back: load frame B during byte 3 of frame A → in_ready=0 until B transfers; B's byte 0 arrives exactly GAP_CYCLES+1 cycles after A's byte 11 is accepted. A third in_valid while the slot is full is ignored.
- Reset asserted at byte 6 of a frame with the slot full:
  - data_valid=0 immediately;
  - after release: in_ready=1, busy=0, frame_count=0;
  - no residual bytes.
- Loopback through the parser: 1000 random triples with random data_ready, GAP_CYCLES=0 and GAP_CYCLES=2 → the parser's latitude/longitude/timestamp equal the inputs.
- Counter wrap with CNT_W=4: 17 frames → frame_count reads 1.
